// File: rtl/seq_multdiv_pkg.sv
// ---------------------------------------------------------------------------
// seq_multdiv_pkg
// Shared types and constants for the iterative signed multiply/divide unit.
//   WIDTH        operand/result width (only 32 is supported)
//   MUL_CYCLES   Booth iterations (two multiplier bits retired per cycle)
//   DIV_CYCLES   non-restoring divide iterations (one quotient bit per cycle)
//   INT_MIN      most negative 32-bit value, the one divide-overflow dividend
//   state_t      control FSM states
//   booth_digit_t and booth_decode: radix-4 Booth recoding of a bit triplet
// ---------------------------------------------------------------------------
package seq_multdiv_pkg;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = WIDTH / 2;
  localparam int DIV_CYCLES = WIDTH;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES);

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_POS2,
    BOOTH_NEG1,
    BOOTH_NEG2
  } booth_digit_t;

  // Triplet is {q[i+1], q[i], q[i-1]}; the digit is -2*q[i+1] + q[i] + q[i-1].
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t digit;
    case (bits)
      3'b001, 3'b010: digit = BOOTH_POS1;
      3'b011:         digit = BOOTH_POS2;
      3'b100:         digit = BOOTH_NEG2;
      3'b101, 3'b110: digit = BOOTH_NEG1;
      default:        digit = BOOTH_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/seq_multdiv_booth_r4_sel.sv
// ---------------------------------------------------------------------------
// booth_r4_sel
// Combinational radix-4 Booth addend selector.
//   i_bits          {q[1], q[0], q[-1]} multiplier triplet
//   i_multiplicand  registered multiplicand M (two's complement)
//   o_addend        34-bit signed addend: 0, +M, +2M, -M or -2M
// ---------------------------------------------------------------------------
module booth_r4_sel
  import seq_multdiv_pkg::*;
(
  input  logic [2:0]       i_bits,
  input  logic [WIDTH-1:0] i_multiplicand,
  output logic [WIDTH+1:0] o_addend
);

  logic [WIDTH+1:0] w_m;
  logic [WIDTH+1:0] w_m2;
  booth_digit_t     w_digit;

  // Two guard bits so that 2M and -2M of INT_MIN are still representable.
  assign w_m     = {{2{i_multiplicand[WIDTH-1]}}, i_multiplicand};
  assign w_m2    = {i_multiplicand[WIDTH-1], i_multiplicand, 1'b0};
  assign w_digit = booth_decode(i_bits);

  always_comb begin
    o_addend = '0;
    case (w_digit)
      BOOTH_POS1: o_addend = w_m;
      BOOTH_POS2: o_addend = w_m2;
      BOOTH_NEG1: o_addend = -w_m;
      BOOTH_NEG2: o_addend = -w_m2;
      default:    o_addend = '0;
    endcase
  end

endmodule

// File: rtl/seq_multdiv.sv
// ---------------------------------------------------------------------------
// seq_multdiv
// Iterative signed multiply / divide responder. A one-cycle ctrl_MULT or
// ctrl_DIV pulse captures the operands; the result appears with a one-cycle
// data_resultRDY pulse 17 (multiply) or 33 (divide) edges later.
//   clock           rising-edge clock
//   reset           synchronous, active-low
//   data_operandA   multiplicand / dividend
//   data_operandB   multiplier / divisor
//   ctrl_MULT       multiply start pulse (wins over ctrl_DIV)
//   ctrl_DIV        divide start pulse
//   data_result     product[31:0] or truncated quotient, held between results
//   data_exception  multiply overflow, divide by zero or INT_MIN / -1
//   data_resultRDY  one-cycle valid pulse, high only in DONE
// ---------------------------------------------------------------------------
module seq_multdiv
  import seq_multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // Shared datapath. Multiply: r_acc = high partial product, r_q = multiplier
  // shifting out / product low half, r_op = multiplicand. Divide: r_acc =
  // signed partial remainder, r_q = dividend shifting out / quotient in,
  // r_op = divisor magnitude.
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_op;
  logic             r_qm1;
  logic             r_neg;
  logic             r_divZero;
  logic             r_divOvf;

  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic [WIDTH+1:0]     w_addend;
  logic [WIDTH+1:0]     w_mulSum;
  logic [2*WIDTH+1:0]   w_mulNext;
  logic                 w_mulOvf;
  logic [WIDTH+1:0]     w_divShift;
  logic [WIDTH+1:0]     w_divSum;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;

  booth_r4_sel u_booth (
    .i_bits         ({r_q[1:0], r_qm1}),
    .i_multiplicand (r_op),
    .o_addend       (w_addend)
  );

  // Booth step: add the selected addend, then arithmetic-shift the whole
  // {acc, q} pair right by two so the next triplet lands in r_q[1:0].
  assign w_mulSum  = r_acc + w_addend;
  assign w_mulNext = {{2{w_mulSum[WIDTH+1]}}, w_mulSum, r_q[WIDTH-1:2]};

  // After the last step {r_acc, r_q} is the sign-extended 64-bit product;
  // overflow means bits 63..31 are not all equal.
  assign w_mulOvf = !((&{r_acc, r_q[WIDTH-1]}) || !(|{r_acc, r_q[WIDTH-1]}));

  // Non-restoring step: subtract while the partial remainder is non-negative,
  // add back otherwise; the new quotient bit is the inverted remainder sign.
  assign w_divShift = {r_acc[WIDTH:0], r_q[WIDTH-1]};
  assign w_divSum   = r_acc[WIDTH+1] ? (w_divShift + {2'b00, r_op})
                                     : (w_divShift - {2'b00, r_op});
  assign w_quot     = r_neg ? -r_q : r_q;

  // Magnitudes; INT_MIN maps to 0x80000000, which is correct as unsigned.
  assign w_magA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_magB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Control FSM. A start pulse in any state restarts from the new operands
  // and suppresses the pending RDY; results only update on entry to DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_op        <= '0;
      r_qm1       <= 1'b0;
      r_neg       <= 1'b0;
      r_divZero   <= 1'b0;
      r_divOvf    <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else if (ctrl_MULT) begin
      r_state <= MUL;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= data_operandB;
      r_op    <= data_operandA;
      r_qm1   <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (ctrl_DIV) begin
      r_state   <= DIV;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= w_magA;
      r_op      <= w_magB;
      r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_divZero <= (data_operandB == '0);
      r_divOvf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
      r_rdy     <= 1'b0;
    end else begin
      case (r_state)
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_state     <= DONE;
            r_result    <= r_q;
            r_exception <= w_mulOvf;
            r_rdy       <= 1'b1;
          end else begin
            r_acc <= w_mulNext[2*WIDTH+1:WIDTH];
            r_q   <= w_mulNext[WIDTH-1:0];
            r_qm1 <= r_q[1];
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV: begin
          if (r_cnt == DIV_LAST) begin
            r_state     <= DONE;
            r_result    <= r_divZero ? '0 : w_quot;
            r_exception <= r_divZero | r_divOvf;
            r_rdy       <= 1'b1;
          end else begin
            r_acc <= w_divSum;
            r_q   <= {r_q[WIDTH-2:0], ~w_divSum[WIDTH+1]};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_seq_multdiv.sv
// ---------------------------------------------------------------------------
// tb_seq_multdiv
// Self-checking bench for seq_multdiv: directed cases for latency, overflow,
// divide-by-zero, restart and reset, followed by randomized operations
// compared against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] prevResult = 32'h0;

  always #5 clock = ~clock;

  seq_multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Reference: {exception, result} from signed integer arithmetic.
  function automatic logic [32:0] modelOp(input logic isMul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    logic [31:0] lo;
    if (isMul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {(p != longint'($signed(lo))), lo};
    end else if (b == 32'h0) begin
      return {1'b1, 32'h0};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      q = $signed(a) / $signed(b);
      return {1'b0, 32'(q)};
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives a one-cycle pulse sampled by the next
  // rising edge (edge 0), then returns at the following negedge.
  task automatic applyStimulus(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic runOp(input string tag, input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int          edges;
    int          expLat;
    logic        held;
    exp    = modelOp(mul, a, b);
    expLat = mul ? 17 : 33;
    applyStimulus(mul, div, a, b);
    edges = 0;
    held  = 1'b1;
    while (data_resultRDY !== 1'b1 && edges < 100) begin
      if (data_result !== prevResult) held = 1'b0;
      @(negedge clock);
      edges++;
    end
    checkOutput($sformatf("%s_latency", tag), 32'(edges), 32'(expLat));
    checkOutput($sformatf("%s_result", tag), data_result, exp[31:0]);
    checkOutput($sformatf("%s_exception", tag), {31'b0, data_exception}, {31'b0, exp[32]});
    checkOutput($sformatf("%s_hold", tag), {31'b0, held}, 32'd1);
    @(negedge clock);
    checkOutput($sformatf("%s_rdyPulse", tag), {31'b0, data_resultRDY}, 32'd0);
    prevResult = exp[31:0];
  endtask

  initial begin
    logic        rdySeen;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;

    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    repeat (2) @(negedge clock);
    checkOutput("reset_result", data_result, 32'h0);
    checkOutput("reset_exception", {31'b0, data_exception}, 32'h0);
    checkOutput("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset      = 1'b1;
    prevResult = 32'h0;
    @(negedge clock);

    runOp("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    runOp("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    runOp("mul_intmin", 1'b1, 1'b0, 32'h8000_0000, 32'd1);
    runOp("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    runOp("div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    runOp("div_by0", 1'b0, 1'b1, 32'd5, 32'd0);
    runOp("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Divide started at edge 0, multiply restart at edge 10.
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    rdySeen = 1'b0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdySeen = 1'b1;
    end
    runOp("restart", 1'b1, 1'b0, 32'd6, 32'd7);
    repeat (12) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdySeen = 1'b1;
    end
    checkOutput("restart_noStaleRdy", {31'b0, rdySeen}, 32'h0);

    runOp("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd7);

    // Reset at edge 8 of an in-flight multiply.
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (7) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_result", data_result, 32'h0);
    checkOutput("midreset_exception", {31'b0, data_exception}, 32'h0);
    checkOutput("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset      = 1'b1;
    prevResult = 32'h0;
    rdySeen    = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdySeen = 1'b1;
    end
    checkOutput("midreset_noRdy", {31'b0, rdySeen}, 32'h0);
    runOp("after_reset", 1'b1, 1'b0, 32'd3, 32'd4);

    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        3: begin
          a = 32'($urandom_range(0, 2000));
          b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        end
        4: begin
          a = 32'hFFFF_FFFF - 32'($urandom_range(0, 70000));
          b = 32'($urandom_range(0, 70000));
        end
        default: ;
      endcase
      runOp($sformatf("rand%0d_%s", i, op ? "mul" : "div"), op, !op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
